// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI trace capture block: entry layout, FSM states, timestamp width.
package rvfi_trace_pkg;

  localparam int TS_W = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  // 128-bit record: {pc[127:64], insn[63:32], trap[31], ts[30:0]}
  typedef struct packed {
    logic [63:0]     pc;
    logic [31:0]     insn;
    logic            trap;
    logic [TS_W-1:0] ts;
  } trace_entry_t;

  function automatic trace_entry_t make_entry(input logic [63:0]     pc,
                                              input logic [31:0]     insn,
                                              input logic            trap,
                                              input logic [TS_W-1:0] ts);
    trace_entry_t e;
    e.pc   = pc;
    e.insn = insn;
    e.trap = trap;
    e.ts   = ts;
    return e;
  endfunction

endpackage

// File: rtl/rvfi_trace_capture_if.sv
// Valid/ready stream carrying captured trace entries from the capture block to a reader.
interface rvfi_trace_capture_if;
  import rvfi_trace_pkg::*;

  logic         valid;
  logic         ready;
  trace_entry_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rvfi_trace_fifo_2w1r.sv
// Circular FIFO accepting up to two writes and one read per cycle; head holds its last value when empty.
module rvfi_trace_fifo_2w1r
  import rvfi_trace_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush,
  input  logic [1:0]    push_cnt,
  input  trace_entry_t  wdata0,
  input  trace_entry_t  wdata1,
  input  logic          pop,
  output trace_entry_t  head,
  output logic          not_empty,
  output logic [LW-1:0] level,
  output logic [LW-1:0] free
);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  trace_entry_t  last_q;

  assign level     = level_q;
  assign free      = LW'(DEPTH) - level_q;
  assign not_empty = (level_q != '0);
  assign head      = not_empty ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      last_q  <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push_cnt);
      level_q <= level_q + LW'(push_cnt) - LW'(pop);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
    end
  end

  // NOTE: storage has no reset; pointers and occupancy alone decide which slots are live.
  always_ff @(posedge clk_i) begin
    if (push_cnt != 2'd0) mem[wr_ptr]          <= wdata0;
    if (push_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= wdata1;
  end

endmodule

// File: rtl/rvfi_trace_capture.sv
// CVA6 RVFI (2 commit ports) trace capture: arm/trigger FSM, length limit, drop counter, 2w1r FIFO.
// Optional PC window filter enabled by defining RVFI_TRACE_PC_FILTER_EN.
module rvfi_trace_capture
  import rvfi_trace_pkg::*;
#(
  parameter  int DEPTH  = 64,
  parameter  int XLEN   = 64,
  parameter  int DROP_W = 16,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        rvfi_valid_i,
  input  logic [2*XLEN-1:0] rvfi_pc_i,
  input  logic [63:0]       rvfi_insn_i,
  input  logic [1:0]        rvfi_trap_i,
  input  logic              arm_i,
  input  logic [XLEN-1:0]   trigger_pc_i,
  input  logic [15:0]       capture_len_i,
`ifdef RVFI_TRACE_PC_FILTER_EN
  input  logic [XLEN-1:0]   filt_lo_i,
  input  logic [XLEN-1:0]   filt_hi_i,
`endif
  rvfi_trace_capture_if.master trace,
  output logic [1:0]        state_o,
  output logic [LW-1:0]     level_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  trace_state_e      state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q;
  logic [DROP_W:0]   drop_sum;
  logic [TS_W-1:0]   ts_q;

  logic [XLEN-1:0]   pc_p    [2];
  trace_entry_t      entry_p [2];
  logic [1:0]        filt_ok;

  logic              started, stop;
  logic [1:0]        n_want, n_push, n_drop;
  trace_entry_t      want0, want1;

  logic [LW-1:0]     level, free;
  logic              pop, not_empty;

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign pc_p[p]    = rvfi_pc_i[p*XLEN +: XLEN];
    assign entry_p[p] = make_entry(64'(pc_p[p]), rvfi_insn_i[p*32 +: 32], rvfi_trap_i[p], ts_q);
`ifdef RVFI_TRACE_PC_FILTER_EN
    assign filt_ok[p] = (pc_p[p] >= filt_lo_i) && (pc_p[p] < filt_hi_i);
`else
    assign filt_ok[p] = 1'b1;
`endif
  end

  // Retirements are walked in port order so trigger, length stop and push order all agree.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    started = (state_q == ST_CAPTURE);
    stop    = 1'b0;
    n_want  = 2'd0;
    want0   = '0;
    want1   = '0;
    for (int p = 0; p < 2; p++) begin
      if (rvfi_valid_i[p]) begin
        if (state_q == ST_ARMED && !started && pc_p[p] == trigger_pc_i) begin
          started = 1'b1;
          state_d = ST_CAPTURE;
        end
        if (started && !stop) begin
          cnt_d = cnt_d + 16'd1;
          if (filt_ok[p]) begin
            if (n_want == 2'd0) want0 = entry_p[p];
            else                want1 = entry_p[p];
            n_want = n_want + 2'd1;
          end
          if (capture_len_i != 16'd0 && cnt_d == capture_len_i) begin
            stop    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
    end
    if (arm_i) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
      n_want  = 2'd0;
    end
  end

  // Room is judged before this cycle's pop, so a pop never frees space for a same-cycle push.
  assign n_push   = (LW'(n_want) <= free) ? n_want : free[1:0];
  assign n_drop   = n_want - n_push;
  assign drop_sum = {1'b0, drop_q} + {{(DROP_W-1){1'b0}}, n_drop};
  assign pop      = not_empty && trace.ready && !arm_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drop_q  <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_q + TS_W'(1);
      if (arm_i)                 drop_q <= '0;
      else if (drop_sum[DROP_W]) drop_q <= '1;
      else                       drop_q <= drop_sum[DROP_W-1:0];
    end
  end

  rvfi_trace_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush     (arm_i),
    .push_cnt  (n_push),
    .wdata0    (want0),
    .wdata1    (want1),
    .pop       (pop),
    .head      (trace.data),
    .not_empty (not_empty),
    .level     (level),
    .free      (free)
  );

  assign trace.valid = not_empty;
  assign state_o     = state_q;
  assign level_o     = level;
  assign drop_cnt_o  = drop_q;

endmodule
